// File: rtl/frame_row_writer_pkg.sv
// Shared types and geometry helpers for the frame row writer.
// The command encoding matches the line-buffer producer's 2-bit command field.
package frame_writer_pkg;

   typedef enum logic [1:0] {
      CMD_NONE        = 2'd0,
      CMD_FRAME_START = 2'd1,
      CMD_ROW_READY   = 2'd2,
      CMD_FRAME_END   = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD_DECODE,
      ST_ROW_REQ,
      ST_ROW_STREAM,
      ST_ROW_FLUSH
   } state_t;

   // Width of the row/burst/beat counters; far above any supported frame geometry.
   localparam int CNT_W = 16;

   // Two RGB565 pixels per 32-bit word.
   function automatic int words_per_row(input int frame_width);
      return frame_width / 2;
   endfunction

   function automatic int bursts_per_row(input int frame_width, input int burst_words);
      return (frame_width / 2) / burst_words;
   endfunction

endpackage

// File: rtl/frame_row_writer_if.sv
// Command and PSRAM write-burst bus of the frame row writer.
// master = the writer itself, slave = the surrounding producer/controller side.
interface frame_row_writer_if #(
   parameter int ADDR_WIDTH = 21
) ();
   logic [1:0]            command_data;
   logic                  command_data_valid;
   logic                  mem_controller_rdy;
   logic                  wr_cmd_valid;
   logic                  wr_cmd_ready;
   logic [ADDR_WIDTH-1:0] wr_cmd_addr;
   logic [31:0]           wr_data;
   logic                  wr_data_valid;
   logic                  wr_data_ready;

   modport master (
      input  command_data, command_data_valid, wr_cmd_ready, wr_data_ready,
      output mem_controller_rdy, wr_cmd_valid, wr_cmd_addr, wr_data, wr_data_valid
   );

   modport slave (
      output command_data, command_data_valid, wr_cmd_ready, wr_data_ready,
      input  mem_controller_rdy, wr_cmd_valid, wr_cmd_addr, wr_data, wr_data_valid
   );
endinterface

// File: rtl/frame_row_writer_prefetch.sv
// Small first-word-fall-through FIFO holding row-buffer words read ahead of the PSRAM beats.
// Depth need not be a power of two; pointers wrap explicitly.
module row_prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk_mem,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_mem) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk_mem or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assert property (@(posedge clk_mem) disable iff (!reset_n)
                    !(push_i && !pop_i && count_q == CW'(DEPTH)));
   assert property (@(posedge clk_mem) disable iff (!reset_n)
                    !(pop_i && count_q == '0));
endmodule

// File: rtl/frame_row_writer.sv
// Drains completed line-buffer rows into a double-buffered PSRAM frame store as fixed bursts,
// tracking frame start/row/end commands and flagging frames with the wrong row count.
module frame_row_writer
   import frame_writer_pkg::*;
#(
   parameter int FRAME_WIDTH     = 640,
   parameter int FRAME_HEIGHT    = 480,
   parameter int BURST_WORDS     = 32,
   parameter int LINE_RD_LATENCY = 2,
   parameter int FRAME_BASE0     = 0,
   parameter int ADDR_WIDTH      = 21
) (
   input  logic                      clk_mem,
   input  logic                      reset_n,
   frame_row_writer_if.master        bus,
   output logic [9:0]                line_addr,
   input  logic [31:0]               line_data,
   output logic                      frame_done,
   output logic                      frame_error,
   output logic                      display_buffer
);
   localparam int WPR        = words_per_row(FRAME_WIDTH);
   localparam int BPR        = bursts_per_row(FRAME_WIDTH, BURST_WORDS);
   localparam int FIFO_DEPTH = LINE_RD_LATENCY + 2;
   localparam int CW         = $clog2(FIFO_DEPTH + 1);
   localparam int STORE1     = FRAME_BASE0 + WPR * FRAME_HEIGHT;

   state_t                 state_q, state_d;
   cmd_t                   cmd_q, cmd_d;
   logic                   run_q;
   logic                   in_frame_q, in_frame_d;
   logic [CNT_W-1:0]       row_cnt_q, row_cnt_d;
   logic [CNT_W-1:0]       burst_idx_q, burst_idx_d;
   logic [CNT_W-1:0]       beat_q, beat_d;
   logic                   write_store_q, write_store_d;
   logic                   display_q, display_d;
   logic                   done_q, done_d, err_q, err_d;
   logic [9:0]             rd_addr_q, rd_addr_d;
   logic                   rd_done_q, rd_done_d;
   logic [LINE_RD_LATENCY-1:0] rd_pipe_q;

   logic [CW-1:0] fifo_count;
   logic [31:0]   fifo_dout;
   logic          fifo_pop, rd_en;
   int            in_flight;

   row_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clk_mem (clk_mem),
      .reset_n (reset_n),
      .push_i  (rd_pipe_q[LINE_RD_LATENCY-1]),
      .din_i   (line_data),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_count)
   );

   // Issue a read only when every outstanding word is guaranteed a FIFO slot.
   always_comb begin
      in_flight = 0;
      for (int i = 0; i < LINE_RD_LATENCY; i++) in_flight += int'(rd_pipe_q[i]);
      rd_en = (state_q == ST_ROW_REQ || state_q == ST_ROW_STREAM) && !rd_done_q &&
              (int'(fifo_count) + in_flight < FIFO_DEPTH);
   end

   assign bus.mem_controller_rdy = (state_q == ST_IDLE) && run_q;
   assign bus.wr_cmd_valid       = (state_q == ST_ROW_REQ);
   assign bus.wr_data_valid      = (state_q == ST_ROW_STREAM) && (fifo_count != '0);
   assign bus.wr_data            = bus.wr_data_valid ? fifo_dout : 32'd0;
   assign bus.wr_cmd_addr        = (write_store_q ? ADDR_WIDTH'(STORE1) : ADDR_WIDTH'(FRAME_BASE0))
                                 + ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(WPR)
                                 + ADDR_WIDTH'(burst_idx_q) * ADDR_WIDTH'(BURST_WORDS);
   assign fifo_pop       = bus.wr_data_valid && bus.wr_data_ready;
   assign line_addr      = rd_addr_q;
   assign frame_done     = done_q;
   assign frame_error    = err_q;
   assign display_buffer = display_q;

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      in_frame_d    = in_frame_q;
      row_cnt_d     = row_cnt_q;
      burst_idx_d   = burst_idx_q;
      beat_d        = beat_q;
      write_store_d = write_store_q;
      display_d     = display_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      rd_addr_d     = rd_addr_q;
      rd_done_d     = rd_done_q;

      // Address saturates on the last word so line_addr never leaves the row.
      if (rd_en) begin
         if (rd_addr_q == 10'(WPR - 1)) rd_done_d = 1'b1;
         else                           rd_addr_d = rd_addr_q + 10'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.command_data_valid && run_q) begin
               cmd_d   = cmd_t'(bus.command_data);
               state_d = ST_CMD_DECODE;
            end
         end
         ST_CMD_DECODE: begin
            state_d = ST_IDLE;
            case (cmd_q)
               CMD_FRAME_START: begin
                  row_cnt_d  = '0;
                  in_frame_d = 1'b1;
               end
               CMD_ROW_READY: begin
                  if (in_frame_q) begin
                     burst_idx_d = '0;
                     beat_d      = '0;
                     rd_addr_d   = '0;
                     rd_done_d   = 1'b0;
                     state_d     = ST_ROW_REQ;
                  end
               end
               CMD_FRAME_END: begin
                  if (in_frame_q) begin
                     if (row_cnt_q == CNT_W'(FRAME_HEIGHT)) begin
                        done_d        = 1'b1;
                        display_d     = write_store_q;
                        write_store_d = ~write_store_q;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  in_frame_d = 1'b0;
               end
               default: ;
            endcase
         end
         ST_ROW_REQ: begin
            if (bus.wr_cmd_ready) state_d = ST_ROW_STREAM;
         end
         ST_ROW_STREAM: begin
            if (fifo_pop) begin
               if (beat_q == CNT_W'(BURST_WORDS - 1)) begin
                  beat_d      = '0;
                  burst_idx_d = burst_idx_q + CNT_W'(1);
                  if (burst_idx_q == CNT_W'(BPR - 1)) begin
                     row_cnt_d = row_cnt_q + CNT_W'(1);
                     state_d   = ST_ROW_FLUSH;
                  end else begin
                     state_d   = ST_ROW_REQ;
                  end
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         ST_ROW_FLUSH: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_mem or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cmd_q         <= CMD_NONE;
         run_q         <= 1'b0;
         in_frame_q    <= 1'b0;
         row_cnt_q     <= '0;
         burst_idx_q   <= '0;
         beat_q        <= '0;
         write_store_q <= 1'b0;
         display_q     <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         rd_addr_q     <= '0;
         rd_done_q     <= 1'b0;
         rd_pipe_q     <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         run_q         <= 1'b1;
         in_frame_q    <= in_frame_d;
         row_cnt_q     <= row_cnt_d;
         burst_idx_q   <= burst_idx_d;
         beat_q        <= beat_d;
         write_store_q <= write_store_d;
         display_q     <= display_d;
         done_q        <= done_d;
         err_q         <= err_d;
         rd_addr_q     <= rd_addr_d;
         rd_done_q     <= rd_done_d;
         rd_pipe_q     <= (rd_pipe_q << 1) | LINE_RD_LATENCY'(rd_en);
      end
   end

   // Every word read for a row has been written out by the time the row closes.
   assert property (@(posedge clk_mem) disable iff (!reset_n)
                    (state_q == ST_ROW_FLUSH) |-> (fifo_count == '0 && rd_pipe_q == '0));
endmodule
